// File: rtl/fi_inject_scheduler_if.sv
// Configuration-side handshake bundle between the test controller and the
// fault-injection scheduler: one job request (delay, duration, target, mode).
interface fi_inject_scheduler_if #(
  parameter int CNT_W   = 16,
  parameter int DUR_W   = 8,
  parameter int NUM_TGT = 3
);
  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_delay;
  logic [DUR_W-1:0] cfg_duration;
  logic [TGT_W-1:0] cfg_target;
  logic [1:0]       cfg_mode;

  // Test controller side: issues jobs, observes ready.
  modport master (
    output cfg_valid, cfg_delay, cfg_duration, cfg_target, cfg_mode,
    input  cfg_ready
  );

  // Scheduler side: accepts jobs, drives ready.
  modport slave (
    input  cfg_valid, cfg_delay, cfg_duration, cfg_target, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/fi_inject_scheduler.sv
// Fault-injection scheduler: accepts one job, counts out its delay, drives a
// one-hot force strobe plus mode for the programmed duration, then pulses done.
// An abort in WAIT/INJECT cancels the job; reset silently clears everything.
module fi_inject_scheduler #(
  parameter int CNT_W   = 16,
  parameter int DUR_W   = 8,
  parameter int NUM_TGT = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  fi_inject_scheduler_if.slave   cfg,
  input  logic                   abort,
  output logic [NUM_TGT-1:0]     inj_strobe,
  output logic [1:0]             inj_mode,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_err,
  output logic [15:0]            inj_total
);
  localparam int TGT_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam logic [TGT_W:0] TGT_LIMIT = (TGT_W+1)'(NUM_TGT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_INJECT = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [DUR_W-1:0]   dcnt_r, dcnt_s;
  logic [DUR_W-1:0]   dur_r, dur_s;
  logic [TGT_W-1:0]   tgt_r, tgt_s;
  logic [1:0]         mode_r, mode_s;
  logic               hs_s, reject_s, abort_take_s, fin_s, cfg_ready_s;

  logic [NUM_TGT-1:0] inj_strobe_r;
  logic [1:0]         inj_mode_r;
  logic               busy_r, done_r, aborted_r, cfg_err_r;
  logic [15:0]        inj_total_r;

  // One-hot decode of a target index; out-of-range indices decode to zero.
  function automatic logic [NUM_TGT-1:0] tgt_onehot(input logic [TGT_W-1:0] idx);
    logic [NUM_TGT-1:0] oh;
    oh = {NUM_TGT{1'b0}};
    for (int i = 0; i < NUM_TGT; i++) begin
      if (idx == TGT_W'(i)) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // Ready only in IDLE and never while reset is being applied.
  assign cfg_ready_s   = (state_r == ST_IDLE) && !reset;
  assign cfg.cfg_ready = cfg_ready_s;
  assign hs_s          = cfg.cfg_valid && cfg_ready_s;

  assign inj_strobe = inj_strobe_r;
  assign inj_mode   = inj_mode_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign aborted    = aborted_r;
  assign cfg_err    = cfg_err_r;
  assign inj_total  = inj_total_r;

  // Next-state, counter and job-field logic for the job sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    dcnt_s       = dcnt_r;
    dur_s        = dur_r;
    tgt_s        = tgt_r;
    mode_s       = mode_r;
    reject_s     = 1'b0;
    abort_take_s = 1'b0;
    fin_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // abort is deliberately ignored here, even alongside a handshake
        if (hs_s) begin
          if (({1'b0, cfg.cfg_target} >= TGT_LIMIT) || (cfg.cfg_mode == 2'b11)) begin
            reject_s = 1'b1;
          end else begin
            tgt_s   = cfg.cfg_target;
            mode_s  = cfg.cfg_mode;
            dur_s   = cfg.cfg_duration;
            cnt_s   = cfg.cfg_delay;
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          abort_take_s = 1'b1;
          state_s      = ST_IDLE;
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          // zero duration is treated as a single strobe cycle
          dcnt_s  = (dur_r == {DUR_W{1'b0}}) ? {DUR_W{1'b0}} : (dur_r - DUR_W'(1));
          state_s = ST_INJECT;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_INJECT: begin
        // abort beats the final strobe cycle: no done, no count
        if (abort) begin
          abort_take_s = 1'b1;
          state_s      = ST_IDLE;
        end else if (dcnt_r == {DUR_W{1'b0}}) begin
          state_s = ST_FIN;
        end else begin
          dcnt_s = dcnt_r - DUR_W'(1);
        end
      end
      ST_FIN: begin
        fin_s   = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and latched job fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      dcnt_r  <= {DUR_W{1'b0}};
      dur_r   <= {DUR_W{1'b0}};
      tgt_r   <= {TGT_W{1'b0}};
      mode_r  <= 2'b00;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dcnt_r  <= dcnt_s;
      dur_r   <= dur_s;
      tgt_r   <= tgt_s;
      mode_r  <= mode_s;
    end
  end

  // Registered injection-side outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_strobe_r <= {NUM_TGT{1'b0}};
      inj_mode_r   <= 2'b00;
      busy_r       <= 1'b0;
    end else begin
      inj_strobe_r <= (state_s == ST_INJECT) ? tgt_onehot(tgt_s) : {NUM_TGT{1'b0}};
      inj_mode_r   <= (state_s == ST_INJECT) ? mode_s : 2'b00;
      busy_r       <= (state_s == ST_WAIT) || (state_s == ST_INJECT);
    end
  end

  // Single-cycle status pulses toward the controller.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      done_r    <= (state_s == ST_FIN);
      aborted_r <= abort_take_s;
      cfg_err_r <= reject_s;
    end
  end

  // Saturating count of normally completed injections.
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_total_r <= 16'd0;
    end else if (fin_s && (inj_total_r != 16'hFFFF)) begin
      inj_total_r <= inj_total_r + 16'd1;
    end else begin
      inj_total_r <= inj_total_r;
    end
  end
endmodule
